fpu_norm_seq: RTL

FPU_NORM_SEQ -- requirements
Module: fpu_norm_seq

---
 rtl/fpu_norm_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/fpu_norm_seq.sv
// Sequential normalizer for raw single-precision adder sums: handles carry-out,
// zero and underflow-limited left normalization, one shift per clock.
module fpu_norm_seq #(
  parameter int MAX_SHIFT = 23
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [33:0] add_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] norm_o,
  output logic        busy_o,
  output logic [4:0]  shift_cnt_o
);

  // state | meaning
  // IDLE  | waiting for a request
  // CHECK | classify captured sum (zero / carry / normal / needs shift)
  // SHIFT | one left shift per cycle until normalized or limited
  // DONE  | result presented until consumer accepts
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  localparam logic [4:0] MAX_CNT = MAX_SHIFT[4:0];

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] man_q, man_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        armed_q;

  // Keeps req_ready low during reset and raises it on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) armed_q <= 1'b0;
    else         armed_q <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 8'h00;
      man_q   <= 25'h0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && armed_q) begin
          sign_d  = add_i[33];
          exp_d   = add_i[32:25];
          man_d   = add_i[24:0];
          cnt_d   = 5'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (man_q == 25'h0) begin
          exp_d = 8'h00;
        end else if (man_q[24]) begin
          if (exp_q < 8'hFE) begin
            exp_d = exp_q + 8'd1;
            man_d = man_q >> 1;
          end else begin
            exp_d = 8'hFF;
            man_d = 25'h0;
          end
        end else if (!man_q[23] && (exp_q > 8'd1)) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        man_d = {man_q[23:0], 1'b0};
        // Entry to SHIFT guarantees exp_q >= 2; the guard keeps it from wrapping regardless.
        exp_d = (exp_q > 8'd1) ? exp_q - 8'd1 : exp_q;
        cnt_d = cnt_q + 5'd1;
        if (man_d[23] || (exp_d == 8'd1) || (cnt_d == MAX_CNT)) state_d = DONE;
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE) && armed_q;
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign norm_o      = {sign_q, exp_q, man_q[22:0]};
  assign shift_cnt_o = cnt_q;

endmodule
